// File: rtl/touch_pkg.sv
// Shared definitions for the touch conditioning path: FSM state encoding and
// panel calibration defaults.
package touch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } touch_state_t;

    localparam int unsigned DEF_X_OFFSET = 150;
    localparam int unsigned DEF_Y_OFFSET = 300;
    localparam int unsigned DEF_X_SHIFT  = 3;
    localparam int unsigned DEF_Y_SHIFT  = 3;
    localparam int unsigned DEF_X_MAX    = 479;
    localparam int unsigned DEF_Y_MAX    = 271;
    localparam int unsigned DEF_Z_THRESH = 256;

endpackage

// File: rtl/touch_axis_scale.sv
// Per-axis calibration: subtract offset with saturation at zero, right-shift,
// clamp to the panel maximum and truncate to the output width.
module touch_axis_scale #(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned OFFSET = 150,
    parameter int unsigned SHIFT  = 3,
    parameter int unsigned MAX    = 479
) (
    input  logic [IN_W-1:0]  avg,
    output logic [OUT_W-1:0] scaled
);

    logic [31:0] wide;
    logic [31:0] diff;
    logic [31:0] shifted;

    always_comb begin
        wide    = 32'(avg);
        diff    = (wide >= OFFSET) ? (wide - OFFSET) : '0;
        shifted = diff >> SHIFT;
        scaled  = (shifted > MAX) ? OUT_W'(MAX) : OUT_W'(shifted);
    end

endmodule

// File: rtl/touch_conditioner.sv
// Touch conditioner: pressure debounce FSM, block averaging, calibration and a
// frame-synchronous coordinate handoff. Optional macro TOUCH_COND_HYST_EN adds release hysteresis.
module touch_conditioner
    import touch_pkg::*;
#(
    parameter int unsigned IN_W     = 9,
    parameter int unsigned OUT_X_W  = 10,
    parameter int unsigned OUT_Y_W  = 9,
    parameter int unsigned X_OFFSET = DEF_X_OFFSET,
    parameter int unsigned Y_OFFSET = DEF_Y_OFFSET,
    parameter int unsigned X_SHIFT  = DEF_X_SHIFT,
    parameter int unsigned Y_SHIFT  = DEF_Y_SHIFT,
    parameter int unsigned X_MAX    = DEF_X_MAX,
    parameter int unsigned Y_MAX    = DEF_Y_MAX,
    parameter int unsigned Z_THRESH = DEF_Z_THRESH,
    parameter int unsigned Z_HYST   = 32,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic               cclk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [IN_W-1:0]    touch_x,
    input  logic [IN_W-1:0]    touch_y,
    input  logic [IN_W-1:0]    touch_z,
    input  logic               new_frame,
    output logic               pressed,
    output logic               press_event,
    output logic               release_event,
    output logic [OUT_X_W-1:0] x_out,
    output logic [OUT_Y_W-1:0] y_out,
    output logic               coord_valid
);

    localparam int unsigned ACC_W    = IN_W + AVG_LOG2;
    localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE);
    localparam logic [4:0]  BLK_LAST = 5'((1 << AVG_LOG2) - 1);

    touch_state_t       state;
    logic [3:0]         cnt;
    logic               z_hi;
    logic               z_rel;
    logic               cnt_done;
    logic               release_now;

    logic [ACC_W-1:0]   acc_x, acc_y, sum_x, sum_y;
    logic [4:0]         blk_cnt;
    logic               s1_valid;
    logic [IN_W-1:0]    s1_x, s1_y;
    logic [OUT_X_W-1:0] scaled_x, pend_x;
    logic [OUT_Y_W-1:0] scaled_y, pend_y;
    logic               pending_valid;

    always_comb begin
        z_hi = 32'(touch_z) >= Z_THRESH;
`ifdef TOUCH_COND_HYST_EN
        z_rel = 32'(touch_z) < ((Z_THRESH > Z_HYST) ? (Z_THRESH - Z_HYST) : 32'd0);
`else
        z_rel = !z_hi;
`endif
        cnt_done    = (cnt + 4'd1) >= DEB_N;
        release_now = sample_valid && z_rel && cnt_done &&
                      (state == PRESSED || state == DEB_RELEASE);
        sum_x       = acc_x + ACC_W'(touch_x);
        sum_y       = acc_y + ACC_W'(touch_y);
    end

    // IDLE/DEB_PRESS and PRESSED/DEB_RELEASE share arms: cnt is always 0 in
    // IDLE and PRESSED, so one "cnt+1 reaches DEBOUNCE" test covers both entries.
    always_ff @(posedge cclk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_event   <= 1'b0;
            release_event <= 1'b0;
        end else begin
            press_event   <= 1'b0;
            release_event <= 1'b0;
            if (sample_valid) begin
                case (state)
                    IDLE, DEB_PRESS: begin
                        if (z_hi) begin
                            if (cnt_done) begin
                                state       <= PRESSED;
                                cnt         <= '0;
                                pressed     <= 1'b1;
                                press_event <= 1'b1;
                            end else begin
                                state <= DEB_PRESS;
                                cnt   <= cnt + 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED, DEB_RELEASE: begin
                        if (z_rel) begin
                            if (cnt_done) begin
                                state         <= IDLE;
                                cnt           <= '0;
                                pressed       <= 1'b0;
                                release_event <= 1'b1;
                            end else begin
                                state <= DEB_RELEASE;
                                cnt   <= cnt + 4'd1;
                            end
                        end else if (z_hi) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            acc_x         <= '0;
            acc_y         <= '0;
            blk_cnt       <= '0;
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            pend_x        <= '0;
            pend_y        <= '0;
            pending_valid <= 1'b0;
            x_out         <= '0;
            y_out         <= '0;
            coord_valid   <= 1'b0;
        end else begin
            s1_valid    <= 1'b0;
            coord_valid <= 1'b0;
            if (state != PRESSED) begin
                acc_x   <= '0;
                acc_y   <= '0;
                blk_cnt <= '0;
            end else if (sample_valid && !z_rel) begin
                if (blk_cnt == BLK_LAST) begin
                    acc_x    <= '0;
                    acc_y    <= '0;
                    blk_cnt  <= '0;
                    s1_valid <= 1'b1;
                    s1_x     <= IN_W'(sum_x >> AVG_LOG2);
                    s1_y     <= IN_W'(sum_y >> AVG_LOG2);
                end else begin
                    acc_x   <= sum_x;
                    acc_y   <= sum_y;
                    blk_cnt <= blk_cnt + 5'd1;
                end
            end
            // Transfer sees the pending value from before this edge; a result
            // landing on the same edge stays pending for the next frame.
            if (new_frame && pending_valid) begin
                x_out         <= pend_x;
                y_out         <= pend_y;
                coord_valid   <= 1'b1;
                pending_valid <= 1'b0;
            end
            if (s1_valid) begin
                pend_x        <= scaled_x;
                pend_y        <= scaled_y;
                pending_valid <= 1'b1;
            end
            if (release_now) begin
                s1_valid      <= 1'b0;
                pending_valid <= 1'b0;
            end
        end
    end

    touch_axis_scale #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_X_W),
        .OFFSET (X_OFFSET),
        .SHIFT  (X_SHIFT),
        .MAX    (X_MAX)
    ) u_scale_x (
        .avg    (s1_x),
        .scaled (scaled_x)
    );

    touch_axis_scale #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_Y_W),
        .OFFSET (Y_OFFSET),
        .SHIFT  (Y_SHIFT),
        .MAX    (Y_MAX)
    ) u_scale_y (
        .avg    (s1_y),
        .scaled (scaled_y)
    );

endmodule

// File: tb/tb_touch_conditioner.sv
// Directed bench for touch_conditioner: a default instance plus one built with
// a reduced X_MAX to exercise the clamp.
module tb_touch_conditioner;

    logic       cclk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [8:0] touch_x, touch_y, touch_z;
    logic       new_frame;

    logic       pressed, press_event, release_event, coord_valid;
    logic [9:0] x_out;
    logic [8:0] y_out;

    logic       c_pressed, c_press_event, c_release_event, c_coord_valid;
    logic [9:0] c_x_out;
    logic [8:0] c_y_out;

    int n_vec = 0;
    int n_err = 0;
    int n_press = 0;
    int n_release = 0;
    int n_coord = 0;

    always #5 cclk = ~cclk;

    touch_conditioner u_dut (
        .cclk          (cclk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .touch_z       (touch_z),
        .new_frame     (new_frame),
        .pressed       (pressed),
        .press_event   (press_event),
        .release_event (release_event),
        .x_out         (x_out),
        .y_out         (y_out),
        .coord_valid   (coord_valid)
    );

    touch_conditioner #(
        .X_MAX (40)
    ) u_dut_clamp (
        .cclk          (cclk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .touch_z       (touch_z),
        .new_frame     (new_frame),
        .pressed       (c_pressed),
        .press_event   (c_press_event),
        .release_event (c_release_event),
        .x_out         (c_x_out),
        .y_out         (c_y_out),
        .coord_valid   (c_coord_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, observe at the falling edge.
    task automatic cyc(input logic sv, input logic [8:0] x, input logic [8:0] y,
                       input logic [8:0] z, input logic nf);
        sample_valid = sv;
        touch_x      = x;
        touch_y      = y;
        touch_z      = z;
        new_frame    = nf;
        @(posedge cclk);
        @(negedge cclk);
        if (press_event === 1'b1)   n_press++;
        if (release_event === 1'b1) n_release++;
        if (coord_valid === 1'b1)   n_coord++;
    endtask

    task automatic samp(input logic [8:0] x, input logic [8:0] y, input logic [8:0] z);
        cyc(1'b1, x, y, z, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 9'd0, 9'd0, 9'd0, 1'b0);
    endtask

    task automatic frame();
        cyc(1'b0, 9'd0, 9'd0, 9'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 1'($urandom));
            check_eq("rst_pressed", 32'(pressed), 32'd0);
            check_eq("rst_press_ev", 32'(press_event), 32'd0);
            check_eq("rst_release_ev", 32'(release_event), 32'd0);
            check_eq("rst_x_out", 32'(x_out), 32'd0);
            check_eq("rst_y_out", 32'(y_out), 32'd0);
            check_eq("rst_coord_valid", 32'(coord_valid), 32'd0);
        end
        reset = 1'b0;
        frame();
        check_eq("post_rst_frame_cv", 32'(coord_valid), 32'd0);
        n_press = 0; n_release = 0; n_coord = 0;

        // Bounce: three high samples then one low, twice
        for (int unsigned r = 0; r < 2; r++) begin
            samp(9'd230, 9'd380, 9'd300);
            samp(9'd230, 9'd380, 9'd300);
            samp(9'd230, 9'd380, 9'd300);
            samp(9'd230, 9'd380, 9'd100);
        end
        check_eq("bounce_pressed", 32'(pressed), 32'd0);
        check_eq("bounce_press_cnt", 32'(n_press), 32'd0);

        // Press and average
        samp(9'd228, 9'd380, 9'd300);
        samp(9'd230, 9'd380, 9'd300);
        samp(9'd232, 9'd380, 9'd300);
        check_eq("press_after3", 32'(pressed), 32'd0);
        samp(9'd230, 9'd380, 9'd300);
        check_eq("press_after4", 32'(pressed), 32'd1);
        check_eq("press_event_now", 32'(press_event), 32'd1);
        for (int unsigned i = 0; i < 4; i++) samp(9'd230, 9'd380, 9'd300);
        check_eq("press_event_once", 32'(n_press), 32'd1);
        idle();
        idle();
        check_eq("no_cv_before_frame", 32'(n_coord), 32'd0);
        frame();
        check_eq("avg_cv", 32'(coord_valid), 32'd1);
        check_eq("avg_x", 32'(x_out), 32'd10);
        check_eq("avg_y", 32'(y_out), 32'd10);
        check_eq("avg_x_clampdut", 32'(c_x_out), 32'd10);
        idle();
        check_eq("avg_cv_once", 32'(n_coord), 32'd1);

        // Saturation at zero
        for (int unsigned i = 0; i < 4; i++) samp(9'd100, 9'd380, 9'd300);
        idle();
        idle();
        frame();
        check_eq("sat_x", 32'(x_out), 32'd0);
        check_eq("sat_y", 32'(y_out), 32'd10);

        // Clamp: (511-150)>>3 = 45, second instance clamps at 40
        for (int unsigned i = 0; i < 4; i++) samp(9'd511, 9'd380, 9'd300);
        idle();
        idle();
        frame();
        check_eq("clamp_x_default", 32'(x_out), 32'd45);
        check_eq("clamp_x_max40", 32'(c_x_out), 32'd40);

        // Coincidence: frame lands on the edge that writes pending
        for (int unsigned i = 0; i < 4; i++) samp(9'd230, 9'd380, 9'd300);
        frame();
        check_eq("coinc_cv", 32'(coord_valid), 32'd0);
        check_eq("coinc_x_hold", 32'(x_out), 32'd45);
        idle();
        frame();
        check_eq("coinc_next_cv", 32'(coord_valid), 32'd1);
        check_eq("coinc_next_x", 32'(x_out), 32'd10);
        frame();
        check_eq("no_pending_cv", 32'(coord_valid), 32'd0);
        check_eq("no_pending_x", 32'(x_out), 32'd10);

`ifdef TOUCH_COND_HYST_EN
        for (int unsigned i = 0; i < 4; i++) samp(9'd100, 9'd380, 9'd240);
        check_eq("hyst_pressed", 32'(pressed), 32'd1);
`endif

        // Release
        n_release = 0;
        n_coord   = 0;
        samp(9'd100, 9'd380, 9'd50);
        samp(9'd100, 9'd380, 9'd50);
        samp(9'd100, 9'd380, 9'd50);
        check_eq("rel_after3", 32'(pressed), 32'd1);
        samp(9'd100, 9'd380, 9'd50);
        check_eq("rel_after4", 32'(pressed), 32'd0);
        check_eq("rel_event_now", 32'(release_event), 32'd1);
        idle();
        idle();
        frame();
        check_eq("rel_cv", 32'(n_coord), 32'd0);
        check_eq("rel_x_hold", 32'(x_out), 32'd10);
        check_eq("rel_y_hold", 32'(y_out), 32'd10);
        check_eq("rel_event_once", 32'(n_release), 32'd1);

        // Reset mid-press
        for (int unsigned i = 0; i < 4; i++) samp(9'd230, 9'd380, 9'd300);
        check_eq("repress", 32'(pressed), 32'd1);
        reset = 1'b1;
        samp(9'd230, 9'd380, 9'd300);
        check_eq("midrst_pressed", 32'(pressed), 32'd0);
        check_eq("midrst_x", 32'(x_out), 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
